// File: rtl/fp_conv_pkg.sv
// fp_conv_pkg
// Shared definitions for the serial-to-parallel sample path that feeds the
// converter. Holds the default sample width, the deserializer state
// enumeration and the bit-counter width.
//
// Contents:
//   WIDTH_DEFAULT - default sample width in bits (converter D width)
//   state_t       - deserializer states IDLE / SHIFT
//   cnt_width()   - bits needed to count 0..w-1 (never less than 1)
//   CNT_W         - counter width for the default sample width
package fp_conv_pkg;

  localparam int WIDTH_DEFAULT = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A one-bit sample would still need a legal (non-zero) counter width.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/sample_deserializer.sv
// sample_deserializer
// Collects a serial two's-complement sample (MSB first) into a parallel
// word and presents it to the converter D input with a valid/ready
// handshake. A frame starts when sframe is high with the MSB on sdata.
// A sample that completes while the previous one is still waiting is
// dropped and recorded in the sticky overrun flag. An sframe arriving
// before the last bit of a frame restarts the frame and pulses frame_err.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   sdata     - serial sample data, MSB first
//   sframe    - frame strobe, high with the MSB
//   d_out     - assembled sample, registered, drives converter D
//   d_valid   - d_out holds a sample not yet consumed
//   d_ready   - consumer takes d_out this cycle
//   busy      - a frame is being shifted in
//   overrun   - sticky: a completed sample was dropped
//   frame_err - one-cycle pulse: a frame was restarted early
//   clr_err   - synchronous clear of overrun (a new overrun wins)
module sample_deserializer
  import fp_conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdata,
  input  logic             sframe,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  input  logic             d_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] TOP_IDX  = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] frame_first;
  logic [CW-1:0]    bit_idx;
  logic             last_bit;
  logic             abort;
  logic             ov_set;
  logic             load;

  // Next-cycle decisions. Each incoming bit is written into its final
  // position (cnt counts bits already taken), so the register never needs
  // a final realignment. shreg_next on the last bit is the finished word,
  // which lets it load into d_out in the same cycle.
  always_comb begin
    frame_first             = '0;
    frame_first[WIDTH-1]    = sdata;
    bit_idx                 = TOP_IDX - cnt;
    shreg_next              = shreg;
    shreg_next[bit_idx]     = sdata;
    last_bit                = (state == SHIFT) && (cnt == LAST_CNT);
    // sframe on the last bit is just data, so only earlier bits can abort.
    abort                   = (state == SHIFT) && !last_bit && sframe;
    ov_set                  = last_bit && d_valid && !d_ready;
    load                    = last_bit && !ov_set;
  end

  assign busy = (state == SHIFT);

  // Frame sequencing plus all registered outputs. A restart after an abort
  // reuses the frame-start path so the current sdata becomes the new MSB.
  // When a load and a transfer coincide, the load wins and d_valid stays
  // high with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort;

      case (state)
        IDLE: begin
          if (sframe) begin
            shreg <= frame_first;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            shreg <= shreg_next;
            cnt   <= '0;
            state <= IDLE;
          end else if (sframe) begin
            shreg <= frame_first;
            cnt   <= CW'(1);
          end else begin
            shreg <= shreg_next;
            cnt   <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (load) begin
        d_out   <= shreg_next;
        d_valid <= 1'b1;
      end else if (d_valid && d_ready) begin
        d_valid <= 1'b0;
      end

      if (ov_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_deserializer.sv
// tb_sample_deserializer
// Self-checking bench for sample_deserializer (WIDTH = 12). A queue-based
// reference model collects serial bits into frames and tracks the output
// handshake; it is compared against the DUT every cycle. A table of
// framed words with hand-derived expected results covers the main
// handshake cases, followed by hand-written abort and reset sequences and
// a randomized run.
module tb_sample_deserializer;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sdata;
  logic         sframe;
  logic [W-1:0] d_out;
  logic         d_valid;
  logic         d_ready;
  logic         busy;
  logic         overrun;
  logic         frame_err;
  logic         clr_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           m_bits[$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_ov;
  logic         m_ferr;

  sample_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sdata     (sdata),
    .sframe    (sframe),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  // Hard stop in case something stalls the stimulus.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_bits.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // One clock edge of the intended behaviour: gather bits into the current
  // frame, and when a frame reaches W bits turn it into a word and offer it
  // to the consumer.
  task automatic modelStep(input bit sd, input bit sf, input bit rdy, input bit clr);
    bit           complete = 1'b0;
    bit           abort    = 1'b0;
    bit           ov_set;
    logic [W-1:0] word     = '0;
    if (m_bits.size() != 0) begin
      if (m_bits.size() == W - 1) begin
        m_bits.push_back(sd);
        complete = 1'b1;
        foreach (m_bits[i]) word = {word[W-2:0], m_bits[i]};
        m_bits.delete();
      end else if (sf) begin
        abort = 1'b1;
        m_bits.delete();
        m_bits.push_back(sd);
      end else begin
        m_bits.push_back(sd);
      end
    end else if (sf) begin
      m_bits.push_back(sd);
    end
    ov_set = complete && m_valid && !rdy;
    if (complete && !ov_set) begin
      m_dout  = word;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (ov_set) m_ov = 1'b1;
    else if (clr) m_ov = 1'b0;
    m_ferr = abort;
  endtask

  task automatic checkOutput();
    compare("d_out", d_out, m_dout);
    compare("d_valid", {11'b0, d_valid}, {11'b0, m_valid});
    compare("busy", {11'b0, busy}, {11'b0, (m_bits.size() != 0)});
    compare("overrun", {11'b0, overrun}, {11'b0, m_ov});
    compare("frame_err", {11'b0, frame_err}, {11'b0, m_ferr});
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare the DUT
  // with the model shortly after the edge.
  task automatic applyStimulus(input bit sd, input bit sf, input bit rdy, input bit clr);
    sdata   = sd;
    sframe  = sf;
    d_ready = rdy;
    clr_err = clr;
    @(posedge clk);
    modelStep(sd, sf, rdy, clr);
    #1;
    checkOutput();
  endtask

  task automatic sendFrame(input logic [W-1:0] word, input bit rdy, input bit rdy_last, input bit clr);
    for (int i = 0; i < W; i++) begin
      applyStimulus(word[W-1-i], (i == 0), (i == W - 1) ? rdy_last : rdy, clr);
    end
  endtask

  typedef struct {
    string        name;
    bit           drain;
    logic [W-1:0] word;
    bit           rdy;
    bit           rdy_last;
    bit           clr;
    logic [W-1:0] exp_dout;
    bit           exp_valid;
    bit           exp_ov;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W-1:0] w_tmp;

    // Each entry: optional draining idle cycle (ready=1), then a frame.
    // Expected values are those one cycle after the last bit.
    vecs[0] = '{"neg125",        1'b0, 12'hF83, 1'b1, 1'b1, 1'b0, 12'hF83, 1'b1, 1'b0};
    vecs[1] = '{"hold_7ff",      1'b1, 12'h7FF, 1'b0, 1'b0, 1'b0, 12'h7FF, 1'b1, 1'b0};
    vecs[2] = '{"overrun_001",   1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 12'h7FF, 1'b1, 1'b1};
    vecs[3] = '{"clr_vs_set",    1'b0, 12'h0A5, 1'b0, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1};
    vecs[4] = '{"clr_and_take",  1'b0, 12'h555, 1'b1, 1'b1, 1'b1, 12'h555, 1'b1, 1'b0};
    vecs[5] = '{"load_on_take",  1'b0, 12'hABC, 1'b0, 1'b1, 1'b0, 12'hABC, 1'b1, 1'b0};
    vecs[6] = '{"plain_0f0",     1'b0, 12'h0F0, 1'b1, 1'b1, 1'b0, 12'h0F0, 1'b1, 1'b0};

    rst_n   = 1'b0;
    sdata   = 1'b0;
    sframe  = 1'b0;
    d_ready = 1'b0;
    clr_err = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset_d_out", d_out, 12'h000);
    compare("reset_d_valid", {11'b0, d_valid}, 12'h000);
    checkOutput();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] table-driven frames");
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].drain) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      sendFrame(vecs[i].word, vecs[i].rdy, vecs[i].rdy_last, vecs[i].clr);
      compare({vecs[i].name, "_dout"}, d_out, vecs[i].exp_dout);
      compare({vecs[i].name, "_valid"}, {11'b0, d_valid}, {11'b0, vecs[i].exp_valid});
      compare({vecs[i].name, "_ovr"}, {11'b0, overrun}, {11'b0, vecs[i].exp_ov});
    end

    $display("[TB] early sframe abort");
    w_tmp = 12'h3C3;
    for (int i = 0; i < 5; i++) applyStimulus(w_tmp[W-1-i], (i == 0), 1'b1, 1'b0);
    w_tmp = 12'h800;
    applyStimulus(w_tmp[W-1], 1'b1, 1'b1, 1'b0);
    compare("abort_ferr_pulse", {11'b0, frame_err}, 12'h001);
    for (int i = 1; i < W; i++) begin
      applyStimulus(w_tmp[W-1-i], 1'b0, 1'b1, 1'b0);
      if (i == 1) compare("abort_ferr_clear", {11'b0, frame_err}, 12'h000);
    end
    compare("abort_d_out", d_out, 12'h800);
    compare("abort_d_valid", {11'b0, d_valid}, 12'h001);

    $display("[TB] reset mid-frame");
    w_tmp = 12'h5A5;
    for (int i = 0; i < 7; i++) applyStimulus(w_tmp[W-1-i], (i == 0), 1'b0, 1'b0);
    sdata  = w_tmp[W-8];
    sframe = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    compare("rst_d_out", d_out, 12'h000);
    compare("rst_d_valid", {11'b0, d_valid}, 12'h000);
    compare("rst_busy", {11'b0, busy}, 12'h000);
    compare("rst_overrun", {11'b0, overrun}, 12'h000);
    compare("rst_frame_err", {11'b0, frame_err}, 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    compare("rst_no_ferr", {11'b0, frame_err}, 12'h000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    sendFrame(12'h0A5, 1'b1, 1'b1, 1'b0);
    compare("rst_next_d_out", d_out, 12'h0A5);
    compare("rst_next_valid", {11'b0, d_valid}, 12'h001);

    $display("[TB] random clean frames");
    for (int f = 0; f < 20; f++) begin
      w_tmp = W'($urandom);
      sendFrame(w_tmp, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      if (($urandom_range(0, 3)) == 0) applyStimulus(1'($urandom), 1'b0, 1'($urandom), 1'b0);
    end

    $display("[TB] random cycles");
    for (int c = 0; c < 800; c++) begin
      applyStimulus(1'($urandom),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_deserializer.md
SAMPLE_DESERIALIZER -- requirements
Module: sample_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12: sample width in bits, matching the converter input D.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sdata, input, 1 bit: serial sample data, MSB first, two's complement.
REQ-005 The block SHALL have port sframe, input, 1 bit: frame strobe, high in the cycle the MSB is on sdata.
REQ-006 The block SHALL have port d_out, output, WIDTH bits: assembled sample, drives converter D.
REQ-007 The block SHALL have port d_valid, output, 1 bit: d_out holds an unconsumed sample.
REQ-008 The block SHALL have port d_ready, input, 1 bit: consumer accepts d_out in this cycle.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, a completed sample was dropped.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse, a frame was aborted by an early sframe.
REQ-012 The block SHALL have port clr_err, input, 1 bit: synchronous clear of overrun.

Function
REQ-013 The block SHALL implement states IDLE and SHIFT with a bit counter cnt (0..WIDTH-1).
REQ-014 In IDLE, sframe=1 SHALL sample sdata into shift bit WIDTH-1, set cnt=1, and enter SHIFT; sframe=0 SHALL leave the state unchanged.
REQ-015 In SHIFT, each cycle SHALL shift sdata in MSB-first and increment cnt.
REQ-016 When the WIDTH-th bit is sampled, the block SHALL return to IDLE and complete the word in that cycle.
REQ-017 On completion, if d_valid=0 or d_ready=1, the word SHALL load into d_out and d_valid SHALL be 1 on the next cycle (latency: 1 cycle after the last bit).
REQ-018 On completion with d_valid=1 and d_ready=0, the word SHALL be discarded, overrun SHALL set, and d_out SHALL be unchanged.
REQ-019 A transfer SHALL occur on any cycle with d_valid=1 and d_ready=1; with no simultaneous load, d_valid SHALL clear next cycle.
REQ-020 d_out SHALL remain stable while d_valid=1 and d_ready=0.
REQ-021 sframe=1 in SHIFT before the last bit SHALL abort the frame, pulse frame_err for one cycle, and restart as in REQ-014 using the current sdata as MSB.
REQ-022 sframe=1 in the same cycle as the WIDTH-th bit SHALL be treated as a data bit only, with no abort.
REQ-023 A new frame SHALL be able to start in the cycle after completion, for back-to-back throughput of one sample per WIDTH cycles.
REQ-024 busy SHALL equal (state==SHIFT).
REQ-025 clr_err=1 SHALL clear overrun; if a set (REQ-018) occurs in the same cycle, set SHALL win.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, shift register=0, d_out=0, d_valid=0, overrun=0, and frame_err=0.
REQ-027 Reset during SHIFT SHALL discard the partial frame without flagging frame_err; the first sframe after release SHALL start a clean frame.

Structure
REQ-028 The shared package fp_conv_pkg SHALL hold the WIDTH default (12), the state enumeration (IDLE, SHIFT), and the counter width constant.
REQ-029 The block SHALL be a single module with no sub-modules; its output register feeds the converter D directly.

Verification
REQ-030 The bench SHALL drive a frame 12'hF83 (-125) with d_ready=1 and require d_out=12'hF83 and d_valid=1 exactly 1 cycle after the 12th bit.
REQ-031 The bench SHALL drive two back-to-back frames 12'h7FF then 12'h001 with d_ready=0 throughout and require d_out=12'h7FF, overrun=1 after the second frame, and d_valid to stay 1.
REQ-032 The bench SHALL assert sframe at bit 5 of a frame and require frame_err to pulse 1 cycle, then drive a new full frame 12'h800 and require d_out=12'h800.
REQ-033 The bench SHALL hold d_ready=1 in the same cycle a new word completes while d_valid=1 and require the new word to load, d_valid to stay 1, and overrun to stay 0.
REQ-034 The bench SHALL assert rst_n=0 mid-frame at bit 7 and require all outputs 0 immediately, no frame_err, and correct capture of the next frame 12'h0A5.
REQ-035 The bench SHALL assert clr_err and an overrun event in the same cycle and require overrun=1.
